// File: rtl/servo_pkg.sv
// Shared types and default constants for the dual-channel servo PWM generator.
package servo_pkg;

    localparam int unsigned US_W = 11;
    typedef logic [US_W-1:0] us_t;

    // Largest width an 11-bit channel can hold; larger limits saturate here.
    localparam int unsigned US_MAX = (1 << US_W) - 1;

    localparam int unsigned X_CENTER_US   = 1500;
    localparam int unsigned Y_CENTER_US   = 1200;
    localparam int unsigned MIN_US_DEF    = 500;
    localparam int unsigned MAX_US_DEF    = 2500;
    localparam int unsigned SLEW_US_DEF   = 20;
    localparam int unsigned PERIOD_US_DEF = 20000;

    // Saturate a command into [lo, hi].
    function automatic us_t clamp_us(input us_t cmd, input us_t lo, input us_t hi);
        us_t r;
        r = cmd;
        if (cmd < lo) begin
            r = lo;
        end else if (cmd > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: frame-boundary clamp, slew limit, width register and pin register.
module servo_channel
    import servo_pkg::*;
#(
    parameter int unsigned MIN_US  = MIN_US_DEF,
    parameter int unsigned MAX_US  = MAX_US_DEF,
    parameter int unsigned RST_US  = X_CENTER_US,
    parameter int unsigned SLEW_US = SLEW_US_DEF,
    parameter int unsigned CNT_W   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_frame_tick,
    input  logic [CNT_W-1:0] i_cnt_next,
    input  us_t              i_cmd,
    output logic             o_pwm,
    output us_t              o_applied
);

    // Limits above the 11-bit range saturate so an out-of-range default cannot wrap.
    localparam int unsigned LO_US     = (MIN_US > US_MAX) ? US_MAX : MIN_US;
    localparam int unsigned HI_US     = (MAX_US > US_MAX) ? US_MAX : MAX_US;
    localparam int unsigned SLEW_LIM  = (SLEW_US > US_MAX) ? US_MAX : SLEW_US;
    localparam int unsigned D_W       = US_W + 1;
    localparam int unsigned CMP_W     = (CNT_W > US_W) ? CNT_W : US_W;
    localparam logic signed [D_W-1:0] SLEW_S = D_W'(SLEW_LIM);

    us_t                   r_applied;
    logic                  r_pwm;
    us_t                   w_clamped;
    logic signed [D_W-1:0] w_diff;
    us_t                   w_step;
    us_t                   w_applied_next;
    logic                  w_pwm_next;

    // Next width (clamp then slew, only on an enabled frame tick) and next pin level.
    always_comb begin
        w_clamped      = clamp_us(i_cmd, us_t'(LO_US), us_t'(HI_US));
        w_diff         = $signed({1'b0, w_clamped}) - $signed({1'b0, r_applied});
        w_step         = w_clamped;
        w_applied_next = r_applied;
        w_pwm_next     = 1'b0;
        if (SLEW_LIM != 0) begin
            if (w_diff > SLEW_S) begin
                w_step = r_applied + us_t'(SLEW_LIM);
            end else if (w_diff < -SLEW_S) begin
                w_step = r_applied - us_t'(SLEW_LIM);
            end
        end
        if (i_frame_tick && i_en) begin
            w_applied_next = w_step;
        end
        w_pwm_next = i_en && (CMP_W'(i_cnt_next) < CMP_W'(w_applied_next));
    end

    // Width and pin registers; pin compare uses the counter value of the coming cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_applied <= us_t'(RST_US);
            r_pwm     <= 1'b0;
        end else begin
            r_applied <= w_applied_next;
            r_pwm     <= w_pwm_next;
        end
    end

    assign o_pwm     = r_pwm;
    assign o_applied = r_applied;

endmodule

// File: rtl/servo_pwm_gen.sv
// Dual-channel 50 Hz servo PWM generator: shared microsecond prescaler and frame counter.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned PERIOD_US = PERIOD_US_DEF,
    parameter int unsigned MIN_US    = MIN_US_DEF,
    parameter int unsigned MAX_US    = MAX_US_DEF,
    parameter int unsigned X_RST_US  = X_CENTER_US,
    parameter int unsigned Y_RST_US  = Y_CENTER_US,
    parameter int unsigned SLEW_US   = SLEW_US_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  us_t  x_us,
    input  us_t  y_us,
    output logic pwm_x,
    output logic pwm_y,
    output logic frame_tick,
    output us_t  x_applied,
    output us_t  y_applied
);

    localparam int unsigned DIV   = CLK_HZ / 1_000_000;
    localparam int unsigned PRE_W = $clog2(DIV);
    localparam int unsigned CNT_W = $clog2(PERIOD_US);

    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_tick;
    logic             w_us_tick;
    logic [PRE_W-1:0] w_pre_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_tick_next;

    // Next prescaler/counter values; frame_tick is precomputed so the register lands on the last cycle.
    always_comb begin
        w_us_tick   = (r_pre == PRE_W'(DIV - 1));
        w_pre_next  = w_us_tick ? '0 : r_pre + PRE_W'(1);
        w_cnt_next  = r_cnt;
        if (w_us_tick) begin
            w_cnt_next = (r_cnt == CNT_W'(PERIOD_US - 1)) ? '0 : r_cnt + CNT_W'(1);
        end
        w_tick_next = (w_pre_next == PRE_W'(DIV - 1)) && (w_cnt_next == CNT_W'(PERIOD_US - 1));
    end

    // Timebase registers; reset restarts the frame from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre        <= '0;
            r_cnt        <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_pre        <= w_pre_next;
            r_cnt        <= w_cnt_next;
            r_frame_tick <= w_tick_next;
        end
    end

    assign frame_tick = r_frame_tick;

    servo_channel #(
        .MIN_US  (MIN_US),
        .MAX_US  (MAX_US),
        .RST_US  (X_RST_US),
        .SLEW_US (SLEW_US),
        .CNT_W   (CNT_W)
    ) u_chan_x (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (en),
        .i_frame_tick (r_frame_tick),
        .i_cnt_next   (w_cnt_next),
        .i_cmd        (x_us),
        .o_pwm        (pwm_x),
        .o_applied    (x_applied)
    );

    servo_channel #(
        .MIN_US  (MIN_US),
        .MAX_US  (MAX_US),
        .RST_US  (Y_RST_US),
        .SLEW_US (SLEW_US),
        .CNT_W   (CNT_W)
    ) u_chan_y (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (en),
        .i_frame_tick (r_frame_tick),
        .i_cnt_next   (w_cnt_next),
        .i_cmd        (y_us),
        .o_pwm        (pwm_y),
        .o_applied    (y_applied)
    );

endmodule
